// File: rtl/dpy_scan_multi.sv
// dpy_scan_multi: multiplexed seven-segment scanner for NUM_DIGITS hex digits.
// Features: configurable scan rate, frame-synchronous (tear-free) number
// update, leading-zero blanking and PWM brightness per digit slot.
// Optional build macro DPY_SCAN_TEST_PATTERN_EN adds a test_mode input that
// forces every lit window to show "8." (segment = 8'hFF).
`timescale 1ns/1ps

module dpy_scan_multi #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    update,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
`ifdef DPY_SCAN_TEST_PATTERN_EN
  input  logic                    test_mode,
`endif
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [7:0]              segment,
  output logic                    frame_done
);

  // Counter widths and the per-brightness-step slot width W.
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = SCAN_DIV >> PWM_BITS;

  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_FULL = {PWM_BITS{1'b1}};

  // Scan state
  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;

  // Pending (written by update) and display (committed at frame boundary)
  logic [4*NUM_DIGITS-1:0] r_pend_num;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_disp_num;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  // Registered outputs
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic [7:0]              r_segment;
  logic                    r_frame_done;

  // Combinational helpers
  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_zero_tail;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_cur_nib;
  logic                    w_cur_dp;
  logic                    w_blank;
  logic [31:0]             w_thresh;
  logic                    w_on;
  logic [NUM_DIGITS-1:0]   w_sel_next;
  logic [7:0]              w_seg_next;

  // Hex nibble to active-high g..a pattern.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  assign w_slot_end  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  // Per-digit views of the display word: nibble, "this and all higher digits
  // are zero" chain for blanking, and the one-hot select pattern.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi]    = r_disp_num[4*gi +: 4];
      assign w_onehot[gi] = (r_idx == IDX_W'(gi));
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_zero_tail[gi] = (w_nib[gi] == 4'h0);
      end else begin : g_chain
        assign w_zero_tail[gi] = (w_nib[gi] == 4'h0) && w_zero_tail[gi+1];
      end
    end
  endgenerate

  assign w_cur_nib = w_nib[r_idx];
  assign w_cur_dp  = r_disp_dp[r_idx];
  // Digit 0 always shows, so an all-zero word still displays a single "0".
  assign w_blank   = blank_lz && (r_idx != '0) && w_zero_tail[r_idx];

  // PWM window: div_cnt = 0 is dead time; full brightness fills the rest of
  // the slot rather than stopping one W short.
  assign w_thresh = 32'(brightness) * 32'(SLOT_W);
  assign w_on     = (r_div_cnt != '0) &&
                    ((brightness == BRIGHT_FULL) || (32'(r_div_cnt) < w_thresh));

  // Scan counters: div_cnt paces the slot, idx walks the digits.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Pending capture and frame-boundary commit; an update on the boundary
  // cycle lands in pending and keeps pending_valid set for the next frame.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_num   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_num   <= '0;
      r_disp_dp    <= '0;
    end else begin
      if (w_frame_end && r_pend_valid) begin
        r_disp_num <= r_pend_num;
        r_disp_dp  <= r_pend_dp;
      end
      if (update) begin
        r_pend_num   <= number;
        r_pend_dp    <= dp;
        r_pend_valid <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Next output values for the current scan position.
  always_comb begin
    w_sel_next = '0;
    w_seg_next = '0;
    if (w_on) begin
      w_sel_next = w_onehot;
      w_seg_next = {w_cur_dp, (w_blank ? 7'h00 : seg7(w_cur_nib))};
`ifdef DPY_SCAN_TEST_PATTERN_EN
      if (test_mode) begin
        w_seg_next = 8'hFF;
      end
`endif
    end
  end

  // Output registers: one cycle behind the scan state.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_sel  <= '0;
      r_segment    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_digit_sel  <= w_sel_next;
      r_segment    <= w_seg_next;
      r_frame_done <= w_frame_end;
    end
  end

  assign digit_sel  = r_digit_sel;
  assign segment    = r_segment;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dpy_scan_multi.sv
// Testbench for dpy_scan_multi with NUM_DIGITS=4, SCAN_DIV=16, PWM_BITS=2.
`timescale 1ns/1ps

module tb_dpy_scan_multi;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int PB = 2;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   number = '0;
  logic [3:0]    dp = '0;
  logic          update = 1'b0;
  logic          blank_lz = 1'b0;
  logic [1:0]    brightness = 2'd3;
`ifdef DPY_SCAN_TEST_PATTERN_EN
  logic          test_mode = 1'b0;
`endif
  logic [3:0]    digit_sel;
  logic [7:0]    segment;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  dpy_scan_multi #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .PWM_BITS(PB)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .number     (number),
    .dp         (dp),
    .update     (update),
    .blank_lz   (blank_lz),
    .brightness (brightness),
`ifdef DPY_SCAN_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .digit_sel  (digit_sel),
    .segment    (segment),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  // segs packs expected windows as {digit3, digit2, digit1, digit0}.
  typedef struct {
    logic [15:0] num;
    logic [3:0]  dpv;
    logic        blz;
    logic [1:0]  br;
    logic [31:0] segs;
    int          on_cnt;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Counts negedges from now until the first frame_done; expects 64.
  task automatic wait_first_frame(input string tag);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk_in);
      n++;
      if (frame_done) seen = 1;
    end
    check({tag, " first_frame_done_cycle"}, 32'(n), 32'd64);
  endtask

  // Observe one full frame (called right after a frame_done sample).
  // Optionally pulses update after sample upd_j / upd_j2 (-1 = none).
  task automatic do_frame(input string tag, input logic [31:0] segs, input int on_cnt,
                          input logic [1:0] br, input logic blz,
                          input int upd_j, input logic [15:0] un, input logic [3:0] ud,
                          input int upd_j2, input logic [15:0] un2, input logic [3:0] ud2);
    int         cnt [4];
    int         slot;
    int         dc;
    bit         exp_on;
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    brightness = br;
    blank_lz   = blz;
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk_in);
      slot    = j / 16;
      dc      = j % 16;
      exp_on  = (dc >= 1) && ((br == 2'd3) || (dc < int'(br) * 4));
      exp_sel = exp_on ? (4'b0001 << slot) : 4'b0000;
      exp_seg = exp_on ? segs[slot*8 +: 8] : 8'h00;
      check($sformatf("%s sel j=%0d", tag, j), 32'(digit_sel), 32'(exp_sel));
      check($sformatf("%s seg j=%0d", tag, j), 32'(segment), 32'(exp_seg));
      check($sformatf("%s frame_done j=%0d", tag, j), 32'(frame_done), (j == 63) ? 32'd1 : 32'd0);
      if (digit_sel != 4'b0000) cnt[slot]++;
      update = 1'b0;
      if (j == upd_j) begin
        update = 1'b1; number = un; dp = ud;
      end
      if (j == upd_j2) begin
        update = 1'b1; number = un2; dp = ud2;
      end
    end
    for (int s = 0; s < 4; s++)
      check($sformatf("%s on_count slot=%0d", tag, s), 32'(cnt[s]), 32'(on_cnt));
    $display("frame %s: segs=%08h brightness=%0d blank_lz=%0d", tag, segs, br, blz);
  endtask

  initial begin
    vecs[0] = '{16'h1A2F, 4'b0100, 1'b0, 2'd3, 32'h06F75B71, 15};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 2'd3, 32'h0000006D, 15};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 2'd3, 32'h0000003F, 15};
    vecs[3] = '{16'h0000, 4'b1000, 1'b1, 2'd2, 32'h8000003F, 7};
    vecs[4] = '{16'h89AB, 4'b0001, 1'b0, 2'd1, 32'h7F6F77FC, 3};
    vecs[5] = '{16'h4567, 4'b0000, 1'b0, 2'd0, 32'h666D7D07, 0};
    vecs[6] = '{16'hCDE0, 4'b0000, 1'b1, 2'd3, 32'h395E793F, 15};
    vecs[7] = '{16'h0300, 4'b0000, 1'b1, 2'd3, 32'h004F3F3F, 15};
    vecs[8] = '{16'h0300, 4'b0000, 1'b0, 2'd3, 32'h3F4F3F3F, 15};

    // Reset state with clock running.
    repeat (3) @(negedge clk_in);
    check("reset digit_sel", 32'(digit_sel), 32'd0);
    check("reset segment", 32'(segment), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    wait_first_frame("post_reset");

    // Idle: zeros displayed; load vector 0 mid-frame (must not show yet).
    do_frame("idle", 32'h3F3F3F3F, 15, 2'd3, 1'b0, 30, vecs[0].num, vecs[0].dpv, -1, 16'h0, 4'h0);

    // Table: each frame checks vector i while loading vector i+1 mid-frame.
    for (int i = 0; i < NV; i++) begin
      if (i + 1 < NV)
        do_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].on_cnt, vecs[i].br, vecs[i].blz,
                 30, vecs[i+1].num, vecs[i+1].dpv, -1, 16'h0, 4'h0);
      else
        do_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].on_cnt, vecs[i].br, vecs[i].blz,
                 -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    end

    // Two updates in one frame: last write wins.
    do_frame("dbl_load", 32'h3F4F3F3F, 15, 2'd3, 1'b0, 10, 16'h1111, 4'h0, 20, 16'h2222, 4'h0);
    // Update on the boundary cycle: displayed one frame later.
    do_frame("dbl_show", 32'h5B5B5B5B, 15, 2'd3, 1'b0, 62, 16'h3333, 4'h0, -1, 16'h0, 4'h0);
    do_frame("bnd_hold", 32'h5B5B5B5B, 15, 2'd3, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    do_frame("bnd_show", 32'h4F4F4F4F, 15, 2'd3, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Asynchronous reset mid-slot.
    repeat (5) @(negedge clk_in);
    check("pre_reset digit_sel", 32'(digit_sel), 32'd1);
    check("pre_reset segment", 32'(segment), 32'h4F);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset digit_sel", 32'(digit_sel), 32'd0);
    check("async_reset segment", 32'(segment), 32'd0);
    check("async_reset frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    wait_first_frame("mid_reset");
    do_frame("after_reset", 32'h3F3F3F3F, 15, 2'd3, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

`ifdef DPY_SCAN_TEST_PATTERN_EN
    test_mode = 1'b1;
    do_frame("test_mode", 32'hFFFFFFFF, 15, 2'd3, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
